// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the shared-ALU controller.
//   ALU_W            operand/result width of the shared ALU
//   ALU_FW           function-select width of the shared ALU
//   alu_ctrl_state_t controller FSM states
package alu_pkg;

    localparam int ALU_W  = 16;
    localparam int ALU_FW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_ctrl_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-input round-robin grant.
//   req[1:0]  in   request lines
//   last      in   index granted most recently (held by the parent)
//   gnt[1:0]  out  one-hot grant, all-zero when nothing requests
//   idx       out  index of the granted requester (0 when none)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       idx
);

    always_comb begin
        gnt = 2'b00;
        idx = 1'b0;
        case (req)
            2'b01: begin
                gnt = 2'b01;
                idx = 1'b0;
            end
            2'b10: begin
                gnt = 2'b10;
                idx = 1'b1;
            end
            2'b11: begin
                // On a tie the requester that did not win last time goes next.
                idx = ~last;
                gnt = last ? 2'b01 : 2'b10;
            end
            default: begin
                gnt = 2'b00;
                idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: sequencer and round-robin arbiter in front of a shared ALU.
// Two requesters hand in (a, b, f) operations; one is granted at a time,
// its operands are registered onto the ALU inputs, the ALU result is
// captured one cycle later and returned on the granted response channel.
//
// Handshake rule for every channel: a transfer happens on a rising edge
// where valid and ready are both high; valid and payload must be held
// until that edge, and ready on a response channel is ignored while the
// matching valid is low.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req0_* / req1_*              operation request channels (valid/ready, a, b, f)
//   rsp0_* / rsp1_*              response channels (valid/ready)
//   rsp_y, rsp_c                 result and carry, shared by both responses
//   alu_a, alu_b, alu_f          drive the external ALU (registered)
//   alu_y, alu_c_out             external ALU result and carry
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int FW    = ALU_FW
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FW-1:0]    req0_f,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FW-1:0]    req1_f,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_c,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FW-1:0]    alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_c_out
);

    alu_ctrl_state_t  state;
    alu_ctrl_state_t  state_next;

    logic             last_grant;
    logic             gnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [FW-1:0]    op_f;
    logic [WIDTH-1:0] res_y;
    logic             res_c;

    logic [1:0]       arb_gnt;
    logic             arb_idx;
    logic             accept;
    logic             rsp_take;

    rr_arb2 u_arb (
        .req  ({req1_valid, req0_valid}),
        .last (last_grant),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    // The arbiter only grants a valid requester, so a grant in IDLE is a
    // completed handshake. Reset masks ready so nothing looks accepted on
    // an edge that reset overrides.
    assign accept     = (state == IDLE) && !rst && (arb_gnt != 2'b00);
    assign req0_ready = (state == IDLE) && !rst && arb_gnt[0];
    assign req1_ready = (state == IDLE) && !rst && arb_gnt[1];

    assign rsp0_valid = (state == RESP) && (gnt == 1'b0);
    assign rsp1_valid = (state == RESP) && (gnt == 1'b1);
    assign rsp_take   = gnt ? rsp1_ready : rsp0_ready;

    assign rsp_y = res_y;
    assign rsp_c = res_c;
    assign alu_a = op_a;
    assign alu_b = op_b;
    assign alu_f = op_f;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = EXEC;
            EXEC:                  state_next = RESP;
            RESP:    if (rsp_take) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;  // requester 0 wins the first tie
            gnt        <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_f       <= '0;
            res_y      <= '0;
            res_c      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_a       <= arb_idx ? req1_a : req0_a;
                op_b       <= arb_idx ? req1_b : req0_b;
                op_f       <= arb_idx ? req1_f : req0_f;
                gnt        <= arb_idx;
                last_grant <= arb_idx;
            end
            // The ALU has had the whole EXEC cycle to settle on op_*.
            if (state == EXEC) begin
                res_y <= alu_y;
                res_c <= alu_c_out;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_f, req1_f;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [15:0] rsp_y;
  logic        rsp_c;
  logic [15:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_f;
  logic        alu_c_out;

  int checks;
  int errors;
  int cyc;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ALU stub: 16-bit add with carry out of bit 15
  assign {alu_c_out, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};

  alu_share_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_f     (req0_f),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_f     (req1_f),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_y      (rsp_y),
    .rsp_c      (rsp_c),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .alu_y      (alu_y),
    .alu_c_out  (alu_c_out)
  );

  // Driver tasks
  task automatic drive_req0(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [2:0] f);
    req0_valid = v; req0_a = a; req0_b = b; req0_f = f;
  endtask

  task automatic drive_req1(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [2:0] f);
    req1_valid = v; req1_a = a; req1_b = b; req1_f = f;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_req0(1'b0, 16'h0, 16'h0, 3'd0);
    drive_req1(1'b0, 16'h0, 16'h0, 3'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp_c} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp_c});
    end
    checks++;
    if ({rsp_y, alu_a, alu_b, alu_f} !== 51'b0) begin
      errors++;
      $display("FAIL reset_data got rsp_y=%h alu_a=%h alu_b=%h alu_f=%0d want 0", rsp_y, alu_a, alu_b, alu_f);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_rsp got %b want 00", {rsp1_valid, rsp0_valid});
    end
  endtask

  task automatic test_single;
    @(posedge clk); #1;
    drive_req0(1'b1, 16'h0005, 16'h0003, 3'd0);
    rsp0_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b want 1", req0_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp0_valid, alu_a, alu_b} !== {2'b00, 16'h0005, 16'h0003}) begin
      errors++;
      $display("FAIL single_exec got rsp=%b alu_a=%h alu_b=%h want 00 0005 0003", {rsp1_valid, rsp0_valid}, alu_a, alu_b);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp0_valid, rsp_y, rsp_c} !== {2'b01, 16'h0008, 1'b0}) begin
      errors++;
      $display("FAIL single_rsp got rsp=%b y=%h c=%b want 01 0008 0", {rsp1_valid, rsp0_valid}, rsp_y, rsp_c);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      errors++;
      $display("FAIL single_consumed got %b want 00", {rsp1_valid, rsp0_valid});
    end
  endtask

  task automatic test_carry;
    @(posedge clk); #1;
    drive_req1(1'b1, 16'hFFFF, 16'h0001, 3'd5);
    rsp1_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++;
      $display("FAIL carry_ready got %b want 10", {req1_ready, req0_ready});
    end
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({alu_f, alu_a, alu_b} !== {3'd5, 16'hFFFF, 16'h0001}) begin
      errors++;
      $display("FAIL carry_alu got f=%0d a=%h b=%h want 5 ffff 0001", alu_f, alu_a, alu_b);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp0_valid, rsp_y, rsp_c} !== {2'b10, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL carry_rsp got rsp=%b y=%h c=%b want 10 0000 1", {rsp1_valid, rsp0_valid}, rsp_y, rsp_c);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      errors++;
      $display("FAIL carry_consumed got %b want 00", {rsp1_valid, rsp0_valid});
    end
  endtask

  task automatic test_contention;
    int i0, i1, g, acc_cyc, prev_cyc;
    logic [15:0] exp_y;
    logic        exp_c;
    logic [1:0]  exp_rdy;
    i0 = 0; i1 = 0; prev_cyc = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    drive_req0(1'b1, 16'h0010, 16'h0100, 3'd1);
    drive_req1(1'b1, 16'hFFF0, 16'h0010, 3'd2);
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      exp_rdy = (g == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      acc_cyc = cyc;
      checks++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        errors++;
        $display("FAIL contention_grant op%0d got %b want %b", k, {req1_ready, req0_ready}, exp_rdy);
      end
      if (k > 0) begin
        checks++;
        if (acc_cyc - prev_cyc != 3) begin
          errors++;
          $display("FAIL contention_spacing op%0d got %0d want 3", k, acc_cyc - prev_cyc);
        end
      end
      prev_cyc = acc_cyc;
      if (g == 0) begin
        exp_y = 16'h0110 + 16'(i0);
        exp_c = 1'b0;
      end else begin
        exp_y = 16'(i1);
        exp_c = 1'b1;
      end
      @(posedge clk); #1;
      if (g == 0) begin
        i0++;
        req0_a = 16'h0010 + 16'(i0);
      end else begin
        i1++;
        req1_b = 16'h0010 + 16'(i1);
      end
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rsp1_valid, rsp0_valid, rsp_y, rsp_c} !== {exp_rdy, exp_y, exp_c}) begin
        errors++;
        $display("FAIL contention_rsp op%0d got rsp=%b y=%h c=%b want %b %h %b",
                 k, {rsp1_valid, rsp0_valid}, rsp_y, rsp_c, exp_rdy, exp_y, exp_c);
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    drive_req0(1'b1, 16'h1234, 16'h0001, 3'd3);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept got %b want 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drive_req1(1'b1, 16'h0100, 16'h0200, 3'd2);
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_exec_ready got %b want 0", req1_ready);
    end
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp1_valid, rsp0_valid, rsp_y, rsp_c, req1_ready} !== {2'b01, 16'h1235, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_stall cyc%0d got rsp=%b y=%h c=%b rdy1=%b want 01 1235 0 0",
                 k, {rsp1_valid, rsp0_valid}, rsp_y, rsp_c, req1_ready);
      end
      checks++;
      if ({alu_a, alu_b, alu_f} !== {16'h1234, 16'h0001, 3'd3}) begin
        errors++;
        $display("FAIL bp_alu cyc%0d got a=%h b=%h f=%0d want 1234 0001 3", k, alu_a, alu_b, alu_f);
      end
      @(posedge clk);
    end
    #1 rsp0_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req1_ready, rsp0_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release got rdy1=%b rsp0=%b want 1 0", req1_ready, rsp0_valid);
    end
    @(posedge clk); #1 req1_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp0_valid, rsp_y, rsp_c} !== {2'b10, 16'h0300, 1'b0}) begin
      errors++;
      $display("FAIL bp_rsp1 got rsp=%b y=%h c=%b want 10 0300 0", {rsp1_valid, rsp0_valid}, rsp_y, rsp_c);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_stray_ready;
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready, rsp_y, alu_a, alu_f} !==
          {4'b0000, 16'h0300, 16'h0100, 3'd2}) begin
        errors++;
        $display("FAIL stray_hold cyc%0d got rsp=%b rdy=%b y=%h a=%h f=%0d want 00 00 0300 0100 2",
                 k, {rsp1_valid, rsp0_valid}, {req1_ready, req0_ready}, rsp_y, alu_a, alu_f);
      end
    end
    @(posedge clk); #1;
    drive_req0(1'b1, 16'h0007, 16'h0009, 3'd1);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_idle got %b want 1", req0_ready);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp0_valid, rsp_y} !== {1'b1, 16'h0010}) begin
      errors++;
      $display("FAIL stray_op got rsp0=%b y=%h want 1 0010", rsp0_valid, rsp_y);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    // Reset during EXEC: requester 0 was just granted, so only a reset of
    // last_grant lets requester 0 win the following tie.
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    drive_req0(1'b1, 16'h00AA, 16'h0011, 3'd4);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_accept got %b want 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready, rsp_c, rsp_y, alu_a, alu_b, alu_f} !== 56'b0) begin
      errors++;
      $display("FAIL rmid_exec_zero got rsp=%b y=%h a=%h b=%h f=%0d want all 0",
               {rsp1_valid, rsp0_valid}, rsp_y, alu_a, alu_b, alu_f);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_exec_norsp got %b want 00", {rsp1_valid, rsp0_valid});
    end
    @(posedge clk); #1;
    drive_req0(1'b1, 16'h0001, 16'h0002, 3'd1);
    drive_req1(1'b1, 16'h0003, 16'h0004, 3'd1);
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rmid_tie1 got %b want 01", {req1_ready, req0_ready});
    end
    // Reset during RESP
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp0_valid, rsp_y} !== {2'b01, 16'h0003}) begin
      errors++;
      $display("FAIL rmid_in_resp got rsp=%b y=%h want 01 0003", {rsp1_valid, rsp0_valid}, rsp_y);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready, rsp_c, rsp_y, alu_a, alu_b, alu_f} !== 56'b0) begin
      errors++;
      $display("FAIL rmid_resp_zero got rsp=%b y=%h a=%h b=%h f=%0d want all 0",
               {rsp1_valid, rsp0_valid}, rsp_y, alu_a, alu_b, alu_f);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rmid_tie2 got %b want 01", {req1_ready, req0_ready});
    end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // rsp1_valid must never rise during the single-request scenario
  logic single_phase;
  always @(negedge clk) begin
    if (single_phase) begin
      checks++;
      if (rsp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_rsp1_quiet got %b want 0", rsp1_valid);
      end
    end
  end

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    single_phase = 1'b0;
    test_reset();
    single_phase = 1'b1;
    test_single();
    single_phase = 1'b0;
    test_carry();
    test_contention();
    test_backpressure();
    test_stray_ready();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and two-port arbiter for the shared 16-bit ALU. Two requesters, such as the execute stage and an address/branch unit, submit `(A, B, F)` operations over valid/ready handshakes. The block grants one requester at a time using round-robin, drives the ALU from registered operands, captures `Y`/`C_out`, and returns the result to the granted requester over a response valid/ready handshake. The ALU sits outside this block. The controller owns its `A`, `B` and `F` inputs and samples its `Y` and `C_out` outputs.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; must match the ALU.
- `FW`, 3, ALU function-select width. `F` is passed opaquely and never decoded.

Ports (`<n>` is 0 or 1; each listed port exists once per requester):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req<n>_valid` in 1: requester n presents an operation.
- `req<n>_ready` out 1: operation accepted on this edge when `valid` is also high.
- `req<n>_a`, `req<n>_b` in WIDTH: operands.
- `req<n>_f` in FW: ALU function code.
- `rsp<n>_valid` out 1: result for requester n is available.
- `rsp<n>_ready` in 1: requester n consumes the result.
- `rsp_y` out WIDTH: result, shared by both response channels.
- `rsp_c` out 1: carry out, shared by both response channels.
- `alu_a`, `alu_b` out WIDTH: ALU operands.
- `alu_f` out FW: ALU function code.
- `alu_y` in WIDTH: ALU result (combinational from `alu_*`).
- `alu_c_out` in 1: ALU carry.

## Operation
- The FSM states are `IDLE`, `EXEC` and `RESP`.
- `IDLE` grant rules:
  - If exactly one `req_valid` is high, that requester is granted.
  - If both are high, the requester not equal to `last_grant` is granted.
  - `req<g>_ready` is asserted combinationally for the granted requester only, and only when it is valid.
  - Both `ready` outputs are low in every other state.
- Handshake edge (`IDLE`, `valid & ready`):
  - The operand registers (`op_a`, `op_b`, `op_f`) load from the granted requester.
  - `gnt` and `last_grant` load the granted index.
  - The FSM moves to `EXEC`.
- `alu_a`, `alu_b` and `alu_f` are driven from the operand registers at all times, so they only change on a handshake edge.
- `EXEC` lasts exactly 1 cycle. At its closing edge, `res_y` and `res_c` load `alu_y` and `alu_c_out`, and the FSM moves to `RESP`.
- `RESP`:
  - `rsp<gnt>_valid` is 1 and the other `rsp_valid` is 0.
  - `rsp_y` and `rsp_c` show the result registers, which hold stable until consumed.
  - On the edge where `rsp<gnt>_ready` is high, the FSM returns to `IDLE`.
- No new request is accepted while in `EXEC` or `RESP`. There is one operation in flight.
- Requesters must hold `valid` and their payload stable until `ready`. A payload change while unaccepted is a requester protocol violation and is not checked.
- `rsp_ready` asserted while `rsp_valid` is low is ignored.
- Reset values:
  - State `IDLE`; `last_grant` = 1, so requester 0 wins the first tie.
  - Operand registers, `res_y`, `res_c` and `gnt` are all 0.
  - All `ready` and `rsp_valid` outputs are 0.
  - `alu_a`, `alu_b` and `alu_f` are 0.
- Reset mid-operation (`EXEC` or `RESP`): the in-flight operation is discarded, no response is issued, and all registers return to their reset values on that edge.
- `rst` has priority over every other event on the same edge.

## Timing
- Accept at edge T. The ALU inputs change after T. The result is captured at edge T+1. `rsp_valid` is high from after T+1.
- Minimum turnaround: handshake edge to the consuming edge is 2 edges. The earliest next accept is the edge after the FSM re-enters `IDLE`.
  - Peak rate is one operation per 3 cycles with `rsp_ready` held high.
- Fairness under continuous contention: grants alternate 0,1,0,1,… A requester waits at most one other operation.
- `rsp_ready` held low stalls indefinitely in `RESP`. Results and outputs stay stable during the stall.
- The ALU path budget is a single full cycle: `alu_*` register to `alu_y`/`alu_c_out`, then to `res_y`.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_W` = 16 and `ALU_FW` = 3.
  - The state enum `alu_ctrl_state_t` {`IDLE`, `EXEC`, `RESP`}.
- Sub-module `rr_arb2` is the 2-input round-robin grant logic.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: one-hot `gnt[1:0]` and `idx`.
  - It is purely combinational.
  - `last_grant` state lives in `alu_share_ctrl`.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
Each scenario uses a bench ALU stub: `alu_y = alu_a + alu_b` (truncated to 16 bits), `alu_c_out` = the carry from bit 15.
- Reset then single request: `req0` = (0x0005, 0x0003, F=0) with `rsp0_ready=1`.
  - `req0_ready` is high at the accept edge.
  - `rsp0_valid=1`, `rsp_y=0x0008`, `rsp_c=0` exactly 1 cycle later.
  - `rsp1_valid` is never set.
- Carry: `req1` = (0xFFFF, 0x0001).
  - `rsp1` returns `rsp_y=0x0000`, `rsp_c=1`.
  - `alu_f` equals the F sent.
- Contention: both requesters valid continuously for 4 operations from reset.
  - Grant order is 0,1,0,1.
  - Each `rsp_y` matches its own operands.
  - The accept spacing is 3 cycles.
- Backpressure: hold `rsp0_ready=0` for 5 cycles while `req1` is valid.
  - `rsp0_valid`, `rsp_y` and `rsp_c` stay stable.
  - `req1_ready` stays 0 and `alu_*` is unchanged.
  - After `rsp0_ready` goes high, `req1` is accepted on the first `IDLE` cycle.
- Reset mid-operation: assert `rst` during `EXEC`, and separately during `RESP`.
  - No `rsp_valid` is issued.
  - All outputs are 0 the cycle after reset.
  - A subsequent tie is granted to requester 0.
- Stray `rsp_ready`: hold `rsp0_ready=1` and `rsp1_ready=1` in `IDLE`. The state and outputs do not change.
